// File: rtl/regfile_2w_sweep_pkg.sv
// Shared definitions for the register file: sweep FSM encoding and the default
// init/offset constants used by the top-level parameters.
package regfile_2w_sweep_pkg;

    typedef enum logic {
        RF_SWEEP = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam logic [31:0] RF_GP_INIT_DEFAULT    = 32'h0000_1800;
    localparam logic [31:0] RF_SP_INIT_DEFAULT    = 32'h0000_2ffe;
    localparam logic [31:0] RF_MIO_OFFSET_DEFAULT = 32'h0000_0020;

endpackage

// File: rtl/regfile_2w_sweep_rf_read_mux.sv
// Read-port select for the register file.
// Ports:
//   raddr            read address
//   stored           regs[raddr] as seen by the parent (don't care when out of range)
//   ready            register file is out of the init sweep
//   we_a/waddr_a/wdata_a, we_b/waddr_b/wdata_b   in-flight writes for forwarding
//   rdata            selected read data
// Address 0 and addresses >= NUM read as 0. With BYPASS=1 a same-cycle write to the
// read address is forwarded, port B taking priority to match the write-side clash rule.
module regfile_2w_sweep_rf_read_mux #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM        = 32,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WIDTH-1:0]      stored,
    input  logic                  ready,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] waddr_a,
    input  logic [WIDTH-1:0]      wdata_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] waddr_b,
    input  logic [WIDTH-1:0]      wdata_b,
    output logic [WIDTH-1:0]      rdata
);

    logic addr_valid;
    assign addr_valid = (raddr != '0) && (32'(raddr) < NUM);

    always_comb begin
        rdata = '0;
        if (addr_valid) begin
            if (BYPASS && ready && we_b && (waddr_b == raddr)) begin
                rdata = wdata_b;
            end else if (BYPASS && ready && we_a && (waddr_a == raddr)) begin
                rdata = wdata_a;
            end else begin
                rdata = stored;
            end
        end
    end

endmodule

// File: rtl/regfile_2w_sweep.sv
// General-purpose register file with two combinational read ports, two write ports
// (B wins on clash), optional write->read bypass, a registered debug read port and the
// CPU_MIO tap. Reset starts a sweep that initialises one register per cycle; busy is
// high for the whole sweep so the control unit can stall.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   we_a/waddr_a/wdata_a        write port A (ALU/WB)
//   we_b/waddr_b/wdata_b        write port B (load/CP0)
//   raddr1/rdata1, raddr2/rdata2  combinational read ports
//   dbg_addr/dbg_data           debug read, 1-cycle latency, never bypassed
//   busy                        init sweep in progress
//   CPU_MIO                     regs[MIO_IDX] + MIO_OFFSET
module regfile_2w_sweep
    import regfile_2w_sweep_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     ADDR_WIDTH = 5,
    parameter int unsigned     NUM        = 32,
    parameter bit              BYPASS     = 1'b1,
    parameter int unsigned     GP_IDX     = 28,
    parameter logic [WIDTH-1:0] GP_INIT   = WIDTH'(RF_GP_INIT_DEFAULT),
    parameter int unsigned     SP_IDX     = 29,
    parameter logic [WIDTH-1:0] SP_INIT   = WIDTH'(RF_SP_INIT_DEFAULT),
    parameter int unsigned     MIO_IDX    = 17,
    parameter logic [31:0]     MIO_OFFSET = RF_MIO_OFFSET_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] waddr_a,
    input  logic [WIDTH-1:0]      wdata_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] waddr_b,
    input  logic [WIDTH-1:0]      wdata_b,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data,
    output logic                  busy,
    output logic [31:0]           CPU_MIO
);

    localparam int unsigned IW = $clog2(NUM);
    localparam logic [IW-1:0] MIO_I = IW'(MIO_IDX);

    logic [WIDTH-1:0] regs [NUM];

    rf_state_t        state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] sweep_val;
    logic             ready;
    logic             wa_ok, wb_ok;
    logic [WIDTH-1:0] dbg_next;

    assign ready = (state_q == RF_READY);
    assign busy  = (state_q == RF_SWEEP);

    assign wa_ok = ready && we_a && (waddr_a != '0) && (32'(waddr_a) < NUM);
    assign wb_ok = ready && we_b && (waddr_b != '0) && (32'(waddr_b) < NUM);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sweep_val = '0;
        if (state_q == RF_SWEEP) begin
            if (32'(ptr_q) == GP_IDX) begin
                sweep_val = GP_INIT;
            end else if (32'(ptr_q) == SP_IDX) begin
                sweep_val = SP_INIT;
            end
            if (32'(ptr_q) == NUM - 1) begin
                state_d = RF_READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RF_SWEEP;
            ptr_q    <= '0;
            dbg_data <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dbg_data <= dbg_next;
        end
    end

    // Storage has no reset of its own so it can map onto RAM; the sweep initialises it.
    // Port B is assigned last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == RF_SWEEP) begin
                regs[ptr_q] <= sweep_val;
            end else begin
                if (wa_ok) regs[waddr_a[IW-1:0]] <= wdata_a;
                if (wb_ok) regs[waddr_b[IW-1:0]] <= wdata_b;
            end
        end
    end

    regfile_2w_sweep_rf_read_mux #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM        (NUM),
        .BYPASS     (BYPASS)
    ) u_rd1 (
        .raddr   (raddr1),
        .stored  (regs[raddr1[IW-1:0]]),
        .ready   (ready),
        .we_a    (we_a),
        .waddr_a (waddr_a),
        .wdata_a (wdata_a),
        .we_b    (we_b),
        .waddr_b (waddr_b),
        .wdata_b (wdata_b),
        .rdata   (rdata1)
    );

    regfile_2w_sweep_rf_read_mux #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM        (NUM),
        .BYPASS     (BYPASS)
    ) u_rd2 (
        .raddr   (raddr2),
        .stored  (regs[raddr2[IW-1:0]]),
        .ready   (ready),
        .we_a    (we_a),
        .waddr_a (waddr_a),
        .wdata_a (wdata_a),
        .we_b    (we_b),
        .waddr_b (waddr_b),
        .wdata_b (wdata_b),
        .rdata   (rdata2)
    );

    // Debug port always shows stored contents, never in-flight writes.
    regfile_2w_sweep_rf_read_mux #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM        (NUM),
        .BYPASS     (1'b0)
    ) u_rd_dbg (
        .raddr   (dbg_addr),
        .stored  (regs[dbg_addr[IW-1:0]]),
        .ready   (ready),
        .we_a    (we_a),
        .waddr_a (waddr_a),
        .wdata_a (wdata_a),
        .we_b    (we_b),
        .waddr_b (waddr_b),
        .wdata_b (wdata_b),
        .rdata   (dbg_next)
    );

    assign CPU_MIO = 32'(regs[MIO_I]) + MIO_OFFSET;

endmodule

// File: tb/tb_regfile_2w_sweep.sv
module tb_regfile_2w_sweep;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a, we_b;
    logic [4:0]  waddr_a, waddr_b, raddr1, raddr2, dbg_addr;
    logic [31:0] wdata_a, wdata_b;

    logic [31:0] p_rdata1, p_rdata2, p_dbg, p_mio;
    logic        p_busy;
    logic [31:0] n_rdata1, n_rdata2, n_dbg, n_mio;
    logic        n_busy;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_2w_sweep #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(p_rdata1), .rdata2(p_rdata2),
        .dbg_addr(dbg_addr), .dbg_data(p_dbg), .busy(p_busy), .CPU_MIO(p_mio)
    );

    regfile_2w_sweep #(.BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset),
        .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
        .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(n_rdata1), .rdata2(n_rdata2),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg), .busy(n_busy), .CPU_MIO(n_mio)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_val(input int a);
        if (a == 28) return 32'h0000_1800;
        if (a == 29) return 32'h0000_2ffe;
        return 32'h0;
    endfunction

    task automatic idle_writes();
        we_a = 1'b0; we_b = 1'b0;
        waddr_a = '0; waddr_b = '0;
        wdata_a = '0; wdata_b = '0;
    endtask

    // Counts edges until both instances leave the sweep; bounded so a stuck FSM still ends.
    task automatic count_sweep(input string tag);
        int n = 0;
        while ((p_busy || n_busy) && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd32);
        check({tag, "_nob_sync"}, {31'b0, n_busy}, {31'b0, p_busy});
    endtask

    task automatic check_init_state(input string tag);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("%s_byp_r1_%0d", tag, i), p_rdata1, init_val(i));
            check($sformatf("%s_byp_r2_%0d", tag, 31 - i), p_rdata2, init_val(31 - i));
            check($sformatf("%s_nob_r1_%0d", tag, i), n_rdata1, init_val(i));
        end
        check({tag, "_mio_byp"}, p_mio, 32'h20);
        check({tag, "_mio_nob"}, n_mio, 32'h20);
    endtask

    initial begin
        reset = 1'b1;
        idle_writes();
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;

        // 1: reset held 3 cycles, then full sweep
        repeat (3) tick();
        check("rst_busy", {31'b0, p_busy}, 32'd1);
        check("rst_dbg", p_dbg, 32'h0);
        reset = 1'b0;
        count_sweep("sweep_len");
        check("busy_low", {31'b0, p_busy}, 32'd0);
        check_init_state("init");
        dbg_addr = 5'd29;
        tick();
        check("dbg_r29", p_dbg, 32'h0000_2ffe);

        // 2: bypass vs stored read
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEAD_BEEF; raddr1 = 5'd5;
        #1;
        check("byp_same_cycle", p_rdata1, 32'hDEAD_BEEF);
        check("nob_same_cycle", n_rdata1, 32'h0);
        tick();
        idle_writes();
        #1;
        check("byp_next_cycle", p_rdata1, 32'hDEAD_BEEF);
        check("nob_next_cycle", n_rdata1, 32'hDEAD_BEEF);

        // 3: clash on r7, port B wins
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h11;
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h22;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("clash_byp_r1", p_rdata1, 32'h22);
        check("clash_byp_r2", p_rdata2, 32'h22);
        check("clash_nob_r1", n_rdata1, 32'h0);
        tick();
        idle_writes();
        #1;
        check("clash_byp_stored", p_rdata1, 32'h22);
        check("clash_nob_stored", n_rdata2, 32'h22);

        // Port A alone bypasses when B targets a different register
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h99;
        we_b = 1'b1; waddr_b = 5'd10; wdata_b = 32'hAA;
        raddr1 = 5'd9; raddr2 = 5'd10;
        #1;
        check("split_byp_a", p_rdata1, 32'h99);
        check("split_byp_b", p_rdata2, 32'hAA);
        tick();
        idle_writes();

        // 4: r0 is never written and always reads 0
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF;
        we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;
        #1;
        check("r0_byp_r1", p_rdata1, 32'h0);
        check("r0_byp_r2", p_rdata2, 32'h0);
        tick();
        idle_writes();
        #1;
        check("r0_nob_r1", n_rdata1, 32'h0);
        check("r0_byp_after", p_rdata2, 32'h0);
        tick();
        check("r0_dbg", p_dbg, 32'h0);

        // 5: CPU_MIO tap and debug latency
        we_a = 1'b1; waddr_a = 5'd17; wdata_a = 32'h100;
        tick();
        idle_writes();
        #1;
        check("mio_byp", p_mio, 32'h120);
        check("mio_nob", n_mio, 32'h120);
        dbg_addr = 5'd17;
        #1;
        check("dbg_latency_old", p_dbg, 32'h0);
        tick();
        check("dbg_r17", p_dbg, 32'h100);
        check("dbg_r17_nob", n_dbg, 32'h100);

        // 6: reset pulse mid-sweep with writes asserted
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("mid_sweep_busy", {31'b0, p_busy}, 32'd1);
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h55;
        we_b = 1'b1; waddr_b = 5'd20; wdata_b = 32'h77;
        reset = 1'b1;
        tick();
        check("restart_dbg", p_dbg, 32'h0);
        reset = 1'b0;
        count_sweep("resweep_len");
        idle_writes();
        check_init_state("resweep");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
